// File: rtl/wht_pkg.sv
// wht_pkg: shared state encoding and width helper for the Walsh-Hadamard engine
package wht_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int owidth_f(int width, int index);
    return width + $clog2(index);
  endfunction
endpackage

// File: rtl/wht_iter_if.sv
// wht_iter_if: sample/result bus between a requester and the transform engine
interface wht_iter_if import wht_pkg::*; #(
  parameter int index = 8,
  parameter int width = 4,
  parameter int owidth = owidth_f(width, index)
);
  logic start;
  logic mode;
  logic [index-1:0][width-1:0] indata;
  logic [index-1:0][owidth-1:0] outdata;
  logic busy;
  logic over;
  modport master (output start, mode, indata, input outdata, busy, over);
  modport slave (input start, mode, indata, output outdata, busy, over);
endinterface

// File: rtl/wht_bfly.sv
// wht_bfly: radix-2 sum/difference butterfly with optional halving
module wht_bfly #(
  parameter int ow = 7
) (
  input  logic signed [ow-1:0] a,
  input  logic signed [ow-1:0] b,
  input  logic                 mode,
  output logic signed [ow-1:0] sum,
  output logic signed [ow-1:0] dif
);
  logic signed [ow:0] s_full, d_full;
  always_comb begin
    s_full = {a[ow-1], a} + {b[ow-1], b};
    d_full = {a[ow-1], a} - {b[ow-1], b};
    sum = mode ? s_full[ow:1] : s_full[ow-1:0];
    dif = mode ? d_full[ow:1] : d_full[ow-1:0];
  end
endmodule

// File: rtl/wht_iter.sv
// wht_iter: iterative Walsh-Hadamard transform, one butterfly stage per clock
module wht_iter import wht_pkg::*; #(
  parameter int index = 8,
  parameter int width = 4,
  parameter int index_width = $clog2(index),
  parameter int owidth = owidth_f(width, index)
) (
  input logic clk,
  input logic rst,
  wht_iter_if.slave bus
);
  state_t state;
  logic [index_width-1:0] s;
  logic md;
  logic [index-1:0][owidth-1:0] w, cap, nxt;
  logic [index-1:0][owidth-1:0] stg [index_width];
  always_comb begin
    for (int k = 0; k < index; k++) cap[k] = owidth'(signed'(bus.indata[k]));
  end
  // every stage has fixed wiring; the live one is picked by s
  for (genvar t = 0; t < index_width; t++) begin : g_stage
    for (genvar p = 0; p < index / 2; p++) begin : g_bfly
      localparam int i = ((p >> t) << (t + 1)) | (p & ((1 << t) - 1));
      localparam int j = i + (1 << t);
      wht_bfly #(.ow(owidth)) u_bfly (
        .a(w[i]), .b(w[j]), .mode(md), .sum(stg[t][i]), .dif(stg[t][j])
      );
    end
  end
  always_comb begin
    nxt = stg[0];
    for (int k = 1; k < index_width; k++) if (s == index_width'(k)) nxt = stg[k];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      s <= '0;
      md <= 1'b0;
      w <= '0;
      bus.outdata <= '0;
      bus.busy <= 1'b0;
      bus.over <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          w <= nxt;
          s <= s + 1'b1;
          if (s == index_width'(index_width - 1)) begin
            bus.outdata <= nxt;
            bus.over <= 1'b1;
            bus.busy <= 1'b0;
            state <= DONE;
          end
        end
        default: begin
          bus.over <= 1'b0;
          state <= bus.start ? RUN : IDLE;
          if (bus.start) begin
            w <= cap;
            md <= bus.mode;
            s <= '0;
            bus.busy <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule
